// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: latches ALU flags, resolves conditional branches, and drives the PC redirect and the timed flush.
// Optional feature macro BRU_PERF_CNT_EN adds saturating branch and mispredict counters.
module branch_resolve_unit #(
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_stall,
   input  logic        i_ex_valid,
   input  logic        i_ex_flag_wr,
   input  logic [4:0]  i_alu_flags,
   input  logic        i_ex_is_branch,
   input  logic [2:0]  i_ex_cond,
   input  logic        i_ex_pred_taken,
   input  logic [15:0] i_ex_target,
   input  logic [15:0] i_ex_pc_plus2,
   output logic [4:0]  o_flags_q,
   output logic        o_redirect_valid,
   output logic [15:0] o_redirect_pc,
   output logic        o_flush
`ifdef BRU_PERF_CNT_EN
   ,
   output logic [15:0] o_perf_branches,
   output logic [15:0] o_perf_mispredicts
`endif
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REDIRECT = 2'd1,
      FLUSH    = 2'd2
   } state_t;

   localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

   // Flag vector layout is {eq, lt, cout, zero, neg}.
   function automatic logic eval_cond(input logic [4:0] flags, input logic [2:0] cond);
      logic res;
      case (cond)
         3'b000:  res = flags[4];
         3'b001:  res = ~flags[4];
         3'b010:  res = flags[3];
         3'b011:  res = ~flags[3];
         3'b100:  res = flags[0];
         3'b101:  res = flags[1];
         3'b110:  res = flags[2];
         default: res = 1'b1;
      endcase
      return res;
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] val);
      return (val == 16'hFFFF) ? val : val + 16'd1;
   endfunction

   state_t      r_state;
   logic [3:0]  r_count;
   logic [4:0]  r_flags;
   logic        r_redirect_valid;
   logic [15:0] r_redirect_pc;
   logic        r_flush;

   state_t      w_state_nxt;
   logic [3:0]  w_count_nxt;
   logic        w_redirect_valid_nxt;
   logic [15:0] w_redirect_pc_nxt;
   logic        w_flush_nxt;

   logic        w_acc;
   logic        w_taken;
   logic        w_mispredict;

   assign w_acc        = i_ex_valid & ~i_stall & (r_state == IDLE);
   // Branch always evaluates against the registered flags, never the ALU's same-cycle flags.
   assign w_taken      = eval_cond(r_flags, i_ex_cond);
   assign w_mispredict = w_acc & i_ex_is_branch & (w_taken != i_ex_pred_taken);

   always_comb begin
      w_state_nxt          = r_state;
      w_count_nxt          = r_count;
      w_redirect_valid_nxt = r_redirect_valid;
      w_redirect_pc_nxt    = r_redirect_pc;
      w_flush_nxt          = r_flush;
      case (r_state)
         IDLE: begin
            if (w_mispredict) begin
               w_state_nxt          = REDIRECT;
               w_redirect_valid_nxt = 1'b1;
               w_flush_nxt          = 1'b1;
               w_redirect_pc_nxt    = w_taken ? i_ex_target : i_ex_pc_plus2;
            end
         end
         REDIRECT: begin
            if (!i_stall) begin
               w_state_nxt          = FLUSH;
               w_redirect_valid_nxt = 1'b0;
               w_count_nxt          = CNT_INIT;
            end
         end
         FLUSH: begin
            if (!i_stall) begin
               if (r_count != 4'd0) begin
                  w_count_nxt = r_count - 4'd1;
               end else begin
                  w_state_nxt = IDLE;
                  w_flush_nxt = 1'b0;
               end
            end
         end
         default: begin
            w_state_nxt          = IDLE;
            w_redirect_valid_nxt = 1'b0;
            w_flush_nxt          = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state          <= IDLE;
         r_count          <= 4'd0;
         r_flags          <= 5'd0;
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= 16'd0;
         r_flush          <= 1'b0;
      end else begin
         r_state          <= w_state_nxt;
         r_count          <= w_count_nxt;
         r_redirect_valid <= w_redirect_valid_nxt;
         r_redirect_pc    <= w_redirect_pc_nxt;
         r_flush          <= w_flush_nxt;
         if (w_acc && i_ex_flag_wr) begin
            r_flags <= i_alu_flags;
         end
      end
   end

   assign o_flags_q        = r_flags;
   assign o_redirect_valid = r_redirect_valid;
   assign o_redirect_pc    = r_redirect_pc;
   assign o_flush          = r_flush;

`ifdef BRU_PERF_CNT_EN
   logic [15:0] r_perf_branches;
   logic [15:0] r_perf_mispredicts;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_perf_branches    <= 16'd0;
         r_perf_mispredicts <= 16'd0;
      end else begin
         if (w_acc && i_ex_is_branch) begin
            r_perf_branches <= sat_inc16(r_perf_branches);
         end
         if (w_mispredict) begin
            r_perf_mispredicts <= sat_inc16(r_perf_mispredicts);
         end
      end
   end

   assign o_perf_branches    = r_perf_branches;
   assign o_perf_mispredicts = r_perf_mispredicts;
`endif

endmodule
